// File: rtl/spi_slave_if.sv
// SPI slave bus: the three wire-side inputs plus the received-byte outputs.
interface spi_slave_if;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_cs;
  logic [7:0] read_value;
  logic       done;
  logic       timeout_expired;
  logic       first_byte;
  logic [7:0] debug_info;

  modport slave (
    input  spi_clk, spi_mosi, spi_cs,
    output read_value, done, timeout_expired, first_byte, debug_info
  );

  modport master (
    output spi_clk, spi_mosi, spi_cs,
    input  read_value, done, timeout_expired, first_byte, debug_info
  );
endinterface

// File: rtl/spi_slave.sv
// Receive-only SPI slave. Oversamples spi_clk/spi_mosi/spi_cs in the clk
// domain, shifts bits on the selected sampling edge and emits one byte per
// done pulse, tagged with whether it was the first byte of its frame.
module spi_slave #(
  parameter int CPOL            = 0,
  parameter int CPHA            = 0,
  parameter int LSBFIRST        = 1,
  parameter int TIMEOUT__NOT_CS = 0,
  parameter int TIMEOUT_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  spi_slave_if.slave  bus
);

  localparam logic           POL      = 1'(CPOL);
  localparam int             IW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT_CYCLES);

  // [0] first flop, [1] synchronised value, [2] previous value for edges
  logic [2:0]    sclk_pipe;
  logic [1:0]    mosi_pipe;
  logic [1:0]    cs_pipe;
  logic          cs_d;

  logic          sclk_sync, sclk_prev, mosi_sync, cs_sync;
  logic          act_edge, deact_edge, sample_edge;
  logic          take_edge, frame_idle, tmo_next;
  logic [7:0]    shift_in;
  logic [IW-1:0] idle_next;

  logic [7:0]    shreg;
  logic [3:0]    bit_cnt;
  logic          first_pending;
  logic [IW-1:0] idle_cnt;
  logic [7:0]    read_value;
  logic          done, first_byte, timeout_expired;

  // Input synchronisers, reset to the lines' idle levels so no false edge
  // is seen on release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_pipe <= {3{POL}};
      mosi_pipe <= 2'b00;
      cs_pipe   <= 2'b11;
      cs_d      <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[1:0], bus.spi_clk};
      mosi_pipe <= {mosi_pipe[0], bus.spi_mosi};
      cs_pipe   <= {cs_pipe[0], bus.spi_cs};
      cs_d      <= cs_sync;
    end
  end

  assign sclk_sync   = sclk_pipe[1];
  assign sclk_prev   = sclk_pipe[2];
  assign mosi_sync   = mosi_pipe[1];
  assign cs_sync     = cs_pipe[1];
  assign act_edge    = (sclk_sync != POL) && (sclk_prev == POL);
  assign deact_edge  = (sclk_sync == POL) && (sclk_prev != POL);
  assign sample_edge = (CPHA != 0) ? deact_edge : act_edge;

  // Edge qualification and frame state. In CS mode an edge landing in the
  // same cycle CS is seen to deassert still counts, so a byte whose last bit
  // races the CS release completes.
  always_comb begin
    take_edge  = 1'b0;
    frame_idle = 1'b1;
    tmo_next   = 1'b1;
    shift_in   = 8'h00;
    idle_next  = idle_cnt;
    if (sample_edge)
      idle_next = '0;
    else if (idle_cnt != IDLE_MAX)
      idle_next = idle_cnt + 1'b1;
    if (TIMEOUT__NOT_CS != 0) begin
      take_edge  = sample_edge;
      frame_idle = (idle_cnt == IDLE_MAX);
      tmo_next   = (idle_next == IDLE_MAX);
    end else begin
      take_edge  = sample_edge && (!cs_sync || !cs_d);
      frame_idle = cs_sync;
      tmo_next   = cs_sync;
    end
    if (LSBFIRST != 0)
      shift_in = {shreg[6:0], mosi_sync};
    else
      shift_in = {mosi_sync, shreg[7:1]};
  end

  // Byte assembly: shift on qualified edges, publish on the 8th bit, and
  // discard any partial byte while the frame is idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg           <= 8'h00;
      bit_cnt         <= 4'd0;
      first_pending   <= 1'b1;
      idle_cnt        <= IDLE_MAX;
      read_value      <= 8'h00;
      done            <= 1'b0;
      first_byte      <= 1'b0;
      timeout_expired <= 1'b1;
    end else begin
      done            <= 1'b0;
      idle_cnt        <= idle_next;
      timeout_expired <= tmo_next;
      if (take_edge) begin
        if (bit_cnt == 4'd7) begin
          read_value    <= shift_in;
          first_byte    <= first_pending;
          first_pending <= 1'b0;
          done          <= 1'b1;
          bit_cnt       <= 4'd0;
          shreg         <= 8'h00;
        end else begin
          shreg   <= shift_in;
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (frame_idle) begin
        shreg         <= 8'h00;
        bit_cnt       <= 4'd0;
        first_pending <= 1'b1;
      end
    end
  end

  assign bus.read_value      = read_value;
  assign bus.done            = done;
  assign bus.first_byte      = first_byte;
  assign bus.timeout_expired = timeout_expired;
  assign bus.debug_info      = {cs_sync, sclk_sync, mosi_sync, first_pending, bit_cnt};

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: four instances cover CS framing (both bit
// orders, modes 0 and 3) and timeout framing.
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] sclk_v = 4'b0100;
  logic [3:0] cs_v = 4'b1111;
  logic       mosi = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic [8:0] q0[$], q1[$], q2[$], q3[$];
  int         d0 = 0;

  always #5 clk = ~clk;

  spi_slave_if bus0 ();
  spi_slave_if bus1 ();
  spi_slave_if bus2 ();
  spi_slave_if bus3 ();

  assign bus0.spi_clk = sclk_v[0]; assign bus0.spi_cs = cs_v[0]; assign bus0.spi_mosi = mosi;
  assign bus1.spi_clk = sclk_v[1]; assign bus1.spi_cs = cs_v[1]; assign bus1.spi_mosi = mosi;
  assign bus2.spi_clk = sclk_v[2]; assign bus2.spi_cs = cs_v[2]; assign bus2.spi_mosi = mosi;
  assign bus3.spi_clk = sclk_v[3]; assign bus3.spi_cs = cs_v[3]; assign bus3.spi_mosi = mosi;

  spi_slave #(.CPOL(0), .CPHA(0), .LSBFIRST(1)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  spi_slave #(.CPOL(0), .CPHA(0), .LSBFIRST(0)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
  spi_slave #(.CPOL(1), .CPHA(1), .LSBFIRST(0)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));
  spi_slave #(.CPOL(0), .CPHA(0), .LSBFIRST(1), .TIMEOUT__NOT_CS(1), .TIMEOUT_CYCLES(20))
    dut3 (.clk(clk), .resetn(resetn), .bus(bus3));

  // capture every done pulse as {first_byte, read_value}
  always @(negedge clk) begin
    if (bus0.done) begin q0.push_back({bus0.first_byte, bus0.read_value}); d0++; end
    if (bus1.done) q1.push_back({bus1.first_byte, bus1.read_value});
    if (bus2.done) q2.push_back({bus2.first_byte, bus2.read_value});
    if (bus3.done) q3.push_back({bus3.first_byte, bus3.read_value});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // n bits of b; lsb_wire: bit0 first on the wire, else bit7 first
  task automatic send(input int sel, input logic [7:0] b, input int n,
                      input bit lsb_wire, input bit pol, input bit cpha);
    for (int i = 0; i < n; i++) begin
      logic bv;
      bv = lsb_wire ? b[i] : b[7-i];
      if (!cpha) begin
        mosi = bv; tick(3); sclk_v[sel] = ~pol; tick(3); sclk_v[sel] = pol;
      end else begin
        sclk_v[sel] = ~pol; mosi = bv; tick(3); sclk_v[sel] = pol; tick(3);
      end
    end
  endtask

  initial begin
    // reset state
    tick(3);
    check("rst_rv", 32'(bus0.read_value), 32'h00);
    check("rst_done", 32'(bus0.done), 32'h0);
    check("rst_fb", 32'(bus0.first_byte), 32'h0);
    check("rst_texp", 32'(bus0.timeout_expired), 32'h1);
    check("rst_dbg0", 32'(bus0.debug_info), 32'h90);
    check("rst_dbg2", 32'(bus2.debug_info), 32'hD0);
    check("rst_texp3", 32'(bus3.timeout_expired), 32'h1);
    resetn = 1'b1;
    tick(2);

    // CS frame of five bytes, first wire bit lands in bit 7
    cs_v[0] = 1'b0; tick(4);
    check("cs_active_texp", 32'(bus0.timeout_expired), 32'h0);
    send(0, 8'h81, 8, 1'b0, 1'b0, 1'b0);
    send(0, 8'h40, 8, 1'b0, 1'b0, 1'b0);
    send(0, 8'h41, 8, 1'b0, 1'b0, 1'b0);
    send(0, 8'h42, 8, 1'b0, 1'b0, 1'b0);
    send(0, 8'h43, 8, 1'b0, 1'b0, 1'b0);
    tick(4); cs_v[0] = 1'b1; tick(4);
    check("f1_count", 32'(q0.size()), 32'd5);
    check("f1_done_cycles", 32'(d0), 32'd5);
    check("f1_b0", 32'(q0[0]), 32'h181);
    check("f1_b1", 32'(q0[1]), 32'h040);
    check("f1_b2", 32'(q0[2]), 32'h041);
    check("f1_b3", 32'(q0[3]), 32'h042);
    check("f1_b4", 32'(q0[4]), 32'h043);
    check("f1_end_texp", 32'(bus0.timeout_expired), 32'h1);

    // 7-bit partial frame is dropped
    cs_v[0] = 1'b0; tick(4);
    send(0, 8'hCF, 7, 1'b0, 1'b0, 1'b0);
    check("part_bitcnt", 32'(bus0.debug_info[3:0]), 32'd7);
    cs_v[0] = 1'b1; tick(6);
    check("part_count", 32'(q0.size()), 32'd5);
    check("part_rv_held", 32'(bus0.read_value), 32'h43);
    check("part_bitcnt_clr", 32'(bus0.debug_info[3:0]), 32'd0);
    check("part_fb_held", 32'(bus0.first_byte), 32'h0);

    // fresh frame after the abort, no residue
    cs_v[0] = 1'b0; tick(4);
    send(0, 8'h30, 8, 1'b0, 1'b0, 1'b0);
    send(0, 8'h2D, 8, 1'b0, 1'b0, 1'b0);
    tick(4); cs_v[0] = 1'b1; tick(4);
    check("f3_count", 32'(q0.size()), 32'd7);
    check("f3_b0", 32'(q0[5]), 32'h130);
    check("f3_b1", 32'(q0[6]), 32'h02D);

    // reversed bit order, mode 0
    cs_v[1] = 1'b0; tick(4);
    send(1, 8'h01, 8, 1'b1, 1'b0, 1'b0);
    tick(4); cs_v[1] = 1'b1; tick(4);
    check("msb0_count", 32'(q1.size()), 32'd1);
    check("msb0_m0", 32'(q1[0]), 32'h101);

    // reversed bit order, mode 3
    cs_v[2] = 1'b0; tick(4);
    send(2, 8'h01, 8, 1'b1, 1'b1, 1'b1);
    tick(4); cs_v[2] = 1'b1; tick(4);
    check("msb0_m3_count", 32'(q2.size()), 32'd1);
    check("msb0_m3", 32'(q2[0]), 32'h101);

    // timeout framing, CS held high
    send(3, 8'hA5, 8, 1'b0, 1'b0, 1'b0);
    tick(3);
    send(3, 8'h3C, 8, 1'b0, 1'b0, 1'b0);
    tick(2);
    check("tmo_active", 32'(bus3.timeout_expired), 32'h0);
    check("tmo_count", 32'(q3.size()), 32'd2);
    check("tmo_b0", 32'(q3[0]), 32'h1A5);
    check("tmo_b1", 32'(q3[1]), 32'h03C);
    tick(25);
    check("tmo_expired", 32'(bus3.timeout_expired), 32'h1);
    send(3, 8'h5A, 8, 1'b0, 1'b0, 1'b0);
    tick(4);
    check("tmo_b2", 32'(q3[2]), 32'h15A);

    // async reset mid-byte
    cs_v[0] = 1'b0; tick(4);
    send(0, 8'hF0, 4, 1'b0, 1'b0, 1'b0);
    check("mid_bitcnt", 32'(bus0.debug_info[3:0]), 32'd4);
    resetn = 1'b0; tick(1);
    check("mid_rst_rv", 32'(bus0.read_value), 32'h00);
    check("mid_rst_fb", 32'(bus0.first_byte), 32'h0);
    check("mid_rst_texp", 32'(bus0.timeout_expired), 32'h1);
    check("mid_rst_dbg", 32'(bus0.debug_info), 32'h90);
    resetn = 1'b1; tick(4);
    send(0, 8'hB7, 8, 1'b0, 1'b0, 1'b0);
    tick(4); cs_v[0] = 1'b1; tick(4);
    check("post_rst_count", 32'(q0.size()), 32'd8);
    check("post_rst_b", 32'(q0[7]), 32'h1B7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
